// File: rtl/cmd_dispatch_if.sv
// rtl/cmd_dispatch_if.sv - dispatcher bus: command intake, response byte, calibrate/move/tour handshakes
interface cmd_dispatch_if;
  logic        cmd_rdy;
  logic [15:0] cmd;
  logic        clr_cmd_rdy;
  logic        resp_trmt;
  logic [7:0]  resp_tx_data;
  logic        resp_tx_done;
  logic        cal_go;
  logic        cal_done;
  logic        move_go;
  logic [7:0]  move_hdg;
  logic [3:0]  move_sqrs;
  logic        move_done;
  logic        tour_go;
  logic [2:0]  tour_x;
  logic [2:0]  tour_y;
  logic        busy;
  logic        err;

  modport master (
    output cmd_rdy, cmd, resp_tx_done, cal_done, move_done,
    input  clr_cmd_rdy, resp_trmt, resp_tx_data, cal_go, move_go, move_hdg, move_sqrs,
           tour_go, tour_x, tour_y, busy, err
  );

  modport slave (
    input  cmd_rdy, cmd, resp_tx_done, cal_done, move_done,
    output clr_cmd_rdy, resp_trmt, resp_tx_data, cal_go, move_go, move_hdg, move_sqrs,
           tour_go, tour_x, tour_y, busy, err
  );
endinterface

// File: rtl/cmd_dispatch.sv
// rtl/cmd_dispatch.sv - decodes 16-bit commands, launches calibrate/move/tour, returns one response byte
module cmd_dispatch #(
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic          clk,
  input  logic          rst_n,
  cmd_dispatch_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, DECODE, WAIT_CAL, WAIT_MOVE, RESP, RESP_WAIT} state_t;

  state_t          state, state_n;
  logic [3:0]      op_q;
  logic [7:0]      resp_q, resp_n;
  logic [7:0]      hdg_q;
  logic [3:0]      sqrs_q;
  logic [2:0]      tx_q, ty_q;
  logic [CW-1:0]   wait_cnt;
  logic            clr, cal_go, move_go, tour_go, trmt, err_p;
  logic            cnt_clr, cnt_inc, timed_out;

  assign timed_out = (wait_cnt == LAST_WAIT);

  always_comb begin
    state_n = state;
    resp_n  = resp_q;
    clr     = 1'b0;
    cal_go  = 1'b0;
    move_go = 1'b0;
    tour_go = 1'b0;
    trmt    = 1'b0;
    err_p   = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state)
      IDLE: begin
        // rst_n gate keeps the consume strobe low while reset is held
        if (bus.cmd_rdy && rst_n) begin
          clr     = 1'b1;
          state_n = DECODE;
        end
      end
      DECODE: begin
        cnt_clr = 1'b1;
        case (op_q)
          4'h2: begin cal_go  = 1'b1; state_n = WAIT_CAL;  end
          4'h4: begin move_go = 1'b1; state_n = WAIT_MOVE; end
          4'h6: begin tour_go = 1'b1; resp_n = 8'hA5; state_n = RESP; end
          default: begin err_p = 1'b1; resp_n = 8'hEE; state_n = RESP; end
        endcase
      end
      WAIT_CAL: begin
        if (bus.cal_done) begin
          resp_n  = 8'h5A;
          state_n = RESP;
        end else if (timed_out) begin
          err_p   = 1'b1;
          resp_n  = 8'hEE;
          state_n = RESP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      WAIT_MOVE: begin
        if (bus.move_done) begin
          resp_n  = 8'hA5;
          state_n = RESP;
        end else if (timed_out) begin
          err_p   = 1'b1;
          resp_n  = 8'hEE;
          state_n = RESP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RESP: begin
        trmt    = 1'b1;
        state_n = RESP_WAIT;
      end
      RESP_WAIT: if (bus.resp_tx_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= '0;
      resp_q   <= '0;
      hdg_q    <= '0;
      sqrs_q   <= '0;
      tx_q     <= '0;
      ty_q     <= '0;
      wait_cnt <= '0;
    end else begin
      state  <= state_n;
      resp_q <= resp_n;
      if (cnt_clr)      wait_cnt <= '0;
      else if (cnt_inc) wait_cnt <= wait_cnt + CW'(1);
      // Parameters are captured at consume so they are already valid alongside the go strobe
      if (clr) begin
        op_q <= bus.cmd[15:12];
        if (bus.cmd[15:12] == 4'h4) begin
          hdg_q  <= bus.cmd[11:4];
          sqrs_q <= bus.cmd[3:0];
        end
        if (bus.cmd[15:12] == 4'h6) begin
          tx_q <= bus.cmd[6:4];
          ty_q <= bus.cmd[2:0];
        end
      end
    end
  end

  assign bus.clr_cmd_rdy  = clr;
  assign bus.resp_trmt    = trmt;
  assign bus.resp_tx_data = resp_q;
  assign bus.cal_go       = cal_go;
  assign bus.move_go      = move_go;
  assign bus.move_hdg     = hdg_q;
  assign bus.move_sqrs    = sqrs_q;
  assign bus.tour_go      = tour_go;
  assign bus.tour_x       = tx_q;
  assign bus.tour_y       = ty_q;
  assign bus.busy         = (state != IDLE);
  assign bus.err          = err_p;
endmodule

// File: tb/tb_cmd_dispatch.sv
// tb/tb_cmd_dispatch.sv - self-checking bench for cmd_dispatch against a transaction-level model
module tb_cmd_dispatch;
  logic        clk, rst_n, sel;
  logic        cmd_rdy, resp_tx_done, cal_done, move_done;
  logic [15:0] cmd;
  int          n_checks = 0;
  int          n_errors = 0;

  logic [7:0]  m_hdg;
  logic [3:0]  m_sqrs;
  logic [2:0]  m_tx, m_ty;

  cmd_dispatch_if b64 ();
  cmd_dispatch_if b16 ();

  cmd_dispatch #(.TIMEOUT_CYC(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));
  cmd_dispatch #(.TIMEOUT_CYC(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

  assign b64.cmd_rdy = cmd_rdy;  assign b16.cmd_rdy = cmd_rdy;
  assign b64.cmd = cmd;          assign b16.cmd = cmd;
  assign b64.resp_tx_done = resp_tx_done;  assign b16.resp_tx_done = resp_tx_done;
  assign b64.cal_done = cal_done;          assign b16.cal_done = cal_done;
  assign b64.move_done = move_done;        assign b16.move_done = move_done;

  logic       o_clr, o_trmt, o_cal, o_move, o_tour, o_busy, o_err;
  logic [7:0] o_data, o_hdg;
  logic [3:0] o_sqrs;
  logic [2:0] o_tx, o_ty;
  assign o_clr  = sel ? b16.clr_cmd_rdy  : b64.clr_cmd_rdy;
  assign o_trmt = sel ? b16.resp_trmt    : b64.resp_trmt;
  assign o_data = sel ? b16.resp_tx_data : b64.resp_tx_data;
  assign o_cal  = sel ? b16.cal_go       : b64.cal_go;
  assign o_move = sel ? b16.move_go      : b64.move_go;
  assign o_hdg  = sel ? b16.move_hdg     : b64.move_hdg;
  assign o_sqrs = sel ? b16.move_sqrs    : b64.move_sqrs;
  assign o_tour = sel ? b16.tour_go      : b64.tour_go;
  assign o_tx   = sel ? b16.tour_x       : b64.tour_x;
  assign o_ty   = sel ? b16.tour_y       : b64.tour_y;
  assign o_busy = sel ? b16.busy         : b64.busy;
  assign o_err  = sel ? b16.err          : b64.err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {22'd0, o_clr, o_trmt, o_data}, 32'd0);
    chk({tag, "_go"},  {9'd0, o_cal, o_move, o_tour, o_busy, o_err, o_hdg, o_sqrs, o_tx, o_ty}, 32'd0);
  endtask

  task automatic model_reset();
    m_hdg = '0; m_sqrs = '0; m_tx = '0; m_ty = '0;
  endtask

  // d: wait cycle on which the matching done is raised (0 = never); txl: cycles before resp_tx_done
  // pend_mid: raise cmd_rdy with pc while waiting; rst_at: pulse reset on that wait cycle
  task automatic do_cmd(input logic [15:0] c, input int d, input int txl, input bit skip_consume,
                        input bit pend_mid, input logic [15:0] pc, input int rst_at);
    logic [3:0] op = c[15:12];
    int         t = sel ? 16 : 64;
    logic [7:0] exp_resp;
    int         exp_err_rel, exp_lat;
    int         n_cal = 0, n_move = 0, n_tour = 0, n_errp = 0, n_multi = 0, n_clr = 0;
    int         err_rel = -1, resp_rel = -1, n_trmt = 0;
    logic [7:0] resp = 8'h00;

    if (op == 4'h2 || op == 4'h4) begin
      if (d >= 1 && d <= t) begin
        exp_resp = (op == 4'h2) ? 8'h5A : 8'hA5; exp_err_rel = -1; exp_lat = d + 1;
      end else begin
        exp_resp = 8'hEE; exp_err_rel = t; exp_lat = t + 1;
      end
    end else if (op == 4'h6) begin
      exp_resp = 8'hA5; exp_err_rel = -1; exp_lat = 1;
    end else begin
      exp_resp = 8'hEE; exp_err_rel = 0; exp_lat = 1;
    end

    if (!skip_consume) begin
      @(negedge clk); cmd = c; cmd_rdy = 1'b1; #1;
      for (int k = 0; k < 20 && !o_clr; k++) begin @(negedge clk); #1; end
      chk("consume", 32'(o_clr), 32'd1);
    end
    if (op == 4'h4) begin m_hdg = c[11:4]; m_sqrs = c[3:0]; end
    if (op == 4'h6) begin m_tx = c[6:4]; m_ty = c[2:0]; end

    for (int r = 0; r <= t + 80; r++) begin
      @(negedge clk);
      cmd_rdy   = pend_mid && r >= 2;
      if (pend_mid && r >= 2) cmd = pc;
      cal_done  = (op == 4'h2) && (r == d);
      move_done = (op == 4'h4) && (r == d);
      if (rst_at > 0 && r == rst_at) begin
        rst_n = 1'b0; cal_done = 1'b0; #1;
        chk_zero("rst_mid");
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk); cal_done = (k == 3); #1;
          n_trmt += 32'(o_trmt);
          chk("rst_busy", 32'(o_busy), 32'd0);
        end
        cal_done = 1'b0;
        chk("rst_no_trmt", 32'(n_trmt), 32'd0);
        return;
      end
      #1;
      n_cal += 32'(o_cal); n_move += 32'(o_move); n_tour += 32'(o_tour); n_clr += 32'(o_clr);
      if (32'(o_cal) + 32'(o_move) + 32'(o_tour) > 1) n_multi++;
      if (o_err) begin n_errp++; err_rel = r; end
      if (o_trmt) begin resp = o_data; resp_rel = r; break; end
    end
    cal_done = 1'b0; move_done = 1'b0;

    chk("resp_lat", 32'(resp_rel), 32'(exp_lat));
    chk("resp_data", 32'(resp), 32'(exp_resp));
    chk("cal_go_cnt", 32'(n_cal), 32'(op == 4'h2));
    chk("move_go_cnt", 32'(n_move), 32'(op == 4'h4));
    chk("tour_go_cnt", 32'(n_tour), 32'(op == 4'h6));
    chk("err_cnt", 32'(n_errp), 32'(exp_err_rel >= 0));
    chk("err_cycle", 32'(err_rel), 32'(exp_err_rel));
    chk("go_onehot", 32'(n_multi), 32'd0);
    chk("move_regs", {20'd0, o_hdg, o_sqrs}, {20'd0, m_hdg, m_sqrs});
    chk("tour_regs", {26'd0, o_tx, o_ty}, {26'd0, m_tx, m_ty});

    for (int i = 0; i <= txl; i++) begin
      @(negedge clk);
      resp_tx_done = (i == txl);
      cal_done = (i == 0); move_done = (i == 0);
      #1;
      n_clr += 32'(o_clr);
      chk("hold_busy", 32'(o_busy), 32'd1);
      chk("hold_state", {23'd0, o_trmt, o_data}, {24'd0, exp_resp});
    end
    @(negedge clk); resp_tx_done = 1'b0; cal_done = 1'b0; move_done = 1'b0; #1;
    chk("no_early_consume", 32'(n_clr), 32'd0);
    chk("idle_busy", 32'(o_busy), 32'd0);
    if (pend_mid) chk("pending_consumed", 32'(o_clr), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; cmd_rdy = 1'b0; cmd = '0;
    resp_tx_done = 1'b0; cal_done = 1'b0; move_done = 1'b0;
    model_reset();
    #12;
    chk_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    do_cmd(16'h2000, 50, 3, 0, 0, 16'h0, 0);
    do_cmd(16'h43F3, 5, 0, 0, 0, 16'h0, 0);
    chk("hdg_3f", 32'(o_hdg), 32'h3F);
    chk("sqrs_3", 32'(o_sqrs), 32'h3);
    do_cmd(16'h6052, 0, 2, 0, 0, 16'h0, 0);
    chk("tour_xy", {26'd0, o_tx, o_ty}, {26'd0, 3'd5, 3'd2});
    do_cmd(16'hF123, 0, 1, 0, 0, 16'h0, 0);
    do_cmd(16'h4A51, 64, 1, 0, 0, 16'h0, 0);
    do_cmd(16'h4B72, 20, 1, 0, 1, 16'h6013, 0);
    do_cmd(16'h6013, 0, 1, 1, 0, 16'h0, 0);

    for (int n = 0; n < 30; n++) begin
      logic [15:0] c = 16'($urandom);
      case ($urandom_range(0, 3))
        0: c[15:12] = 4'h2;
        1: c[15:12] = 4'h4;
        2: c[15:12] = 4'h6;
        default: ;
      endcase
      do_cmd(c, $urandom_range(1, 70), $urandom_range(0, 3), 0, 0, 16'h0, 0);
    end

    do_cmd(16'h2000, 0, 0, 0, 0, 16'h0, 5);

    @(negedge clk); rst_n = 1'b0; sel = 1'b1; #1;
    chk_zero("reset16");
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    do_cmd(16'h2000, 0, 1, 0, 0, 16'h0, 0);
    do_cmd(16'h2000, 16, 1, 0, 0, 16'h0, 0);
    do_cmd(16'h4123, 17, 0, 0, 0, 16'h0, 0);
    for (int n = 0; n < 10; n++) begin
      logic [15:0] c = 16'($urandom);
      c[15:12] = ($urandom_range(0, 1) == 0) ? 4'h2 : 4'h4;
      do_cmd(c, $urandom_range(1, 20), $urandom_range(0, 2), 0, 0, 16'h0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
